// File: rtl/median_filter_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | median_filter_ctrl_if                                              |
// | Frame-buffer, median-core and control signals of the sequencer.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface median_filter_ctrl_if #(
   parameter int AW = 12,
   parameter int S  = 8
);
   logic          start;
   logic          abort;
   logic          busy;
   logic          done;
   logic [AW-1:0] rd_addr;
   logic [S-1:0]  rd_data;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [S-1:0]  wr_data;
   logic          core_rst;
   logic          core_en;
   logic [S-1:0]  core_data;
   logic [S-1:0]  core_out;

   modport master (
      input  start, abort, rd_data, core_out,
      output busy, done, rd_addr, wr_en, wr_addr, wr_data,
             core_rst, core_en, core_data
   );

   modport slave (
      output start, abort, rd_data, core_out,
      input  busy, done, rd_addr, wr_en, wr_addr, wr_data,
             core_rst, core_en, core_data
   );
endinterface
`default_nettype wire

// File: rtl/median_filter_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | median_filter_ctrl                                                 |
// | Raster-order 3x3 median sequencer between frame RAMs and the core. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module median_filter_ctrl #(
   parameter int IMG_W   = 64,
   parameter int IMG_H   = 64,
   parameter int S       = 8,
   parameter int MED_LAT = 16,
   parameter int AW      = $clog2(IMG_W*IMG_H)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   median_filter_ctrl_if.master ctl_io
);
   localparam int RW   = $clog2(IMG_H);
   localparam int CW   = $clog2(IMG_W);
   localparam int CNTW = $clog2(MED_LAT + 10);

   localparam logic [RW-1:0]   ROW_LAST  = RW'(IMG_H - 1);
   localparam logic [CW-1:0]   COL_LAST  = CW'(IMG_W - 1);
   localparam logic [CNTW-1:0] LOAD_LAST = CNTW'(9);
   localparam logic [CNTW-1:0] TAP_LAST  = CNTW'(8);
   localparam logic [CNTW-1:0] SORT_LAST = CNTW'(MED_LAT - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLR   = 3'd1,
      S_LOAD  = 3'd2,
      S_SORT  = 3'd3,
      S_WRITE = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t          state_q;
   logic [RW-1:0]   row_q;
   logic [CW-1:0]   col_q;
   logic [CNTW-1:0] cnt_q;
   logic            busy_q, done_q, wr_en_q, core_rst_q, core_en_q;
   logic [AW-1:0]   rd_addr_q, wr_addr_q;
   logic [S-1:0]    wr_data_q;

   logic [3:0]      tap_idx;
   logic [1:0]      tap_r, tap_c;
   logic [RW-1:0]   tap_row;
   logic [CW-1:0]   tap_col;
   logic [AW-1:0]   tap_addr, pix_addr;
   logic            last_pix;

   // Address of the tap to present in the next cycle, clamped to the frame.
   always_comb begin
      tap_idx = (state_q == S_CLR) ? 4'd0 : 4'(cnt_q) + 4'd1;
      if (tap_idx < 4'd3) begin
         tap_r = 2'd0;
         tap_c = 2'(tap_idx);
      end else if (tap_idx < 4'd6) begin
         tap_r = 2'd1;
         tap_c = 2'(tap_idx - 4'd3);
      end else begin
         tap_r = 2'd2;
         tap_c = 2'(tap_idx - 4'd6);
      end
      case (tap_r)
         2'd0:    tap_row = (row_q == '0) ? row_q : row_q - RW'(1);
         2'd1:    tap_row = row_q;
         default: tap_row = (row_q == ROW_LAST) ? row_q : row_q + RW'(1);
      endcase
      case (tap_c)
         2'd0:    tap_col = (col_q == '0) ? col_q : col_q - CW'(1);
         2'd1:    tap_col = col_q;
         default: tap_col = (col_q == COL_LAST) ? col_q : col_q + CW'(1);
      endcase
      tap_addr = AW'(tap_row) * AW'(IMG_W) + AW'(tap_col);
      pix_addr = AW'(row_q) * AW'(IMG_W) + AW'(col_q);
      last_pix = (row_q == ROW_LAST) && (col_q == COL_LAST);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= S_IDLE;
         row_q      <= '0;
         col_q      <= '0;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         wr_en_q    <= 1'b0;
         core_rst_q <= 1'b0;
         core_en_q  <= 1'b0;
         rd_addr_q  <= '0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else if (state_q != S_IDLE && ctl_io.abort) begin
         state_q    <= S_IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         wr_en_q    <= 1'b0;
         core_en_q  <= 1'b0;
         core_rst_q <= 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               core_rst_q <= 1'b0;
               if (ctl_io.start) begin
                  state_q    <= S_CLR;
                  busy_q     <= 1'b1;
                  core_rst_q <= 1'b1;
                  row_q      <= '0;
                  col_q      <= '0;
               end
            end
            S_CLR: begin
               core_rst_q <= 1'b0;
               cnt_q      <= '0;
               rd_addr_q  <= tap_addr;
               state_q    <= S_LOAD;
            end
            S_LOAD: begin
               // Core load runs one cycle behind the address stream.
               if (cnt_q == LOAD_LAST) begin
                  core_en_q <= 1'b0;
                  cnt_q     <= '0;
                  state_q   <= S_SORT;
               end else begin
                  core_en_q <= 1'b1;
                  cnt_q     <= cnt_q + CNTW'(1);
                  if (cnt_q < TAP_LAST) rd_addr_q <= tap_addr;
               end
            end
            S_SORT: begin
               if (cnt_q == SORT_LAST) begin
                  wr_en_q   <= 1'b1;
                  wr_addr_q <= pix_addr;
                  wr_data_q <= ctl_io.core_out;
                  state_q   <= S_WRITE;
               end else begin
                  cnt_q <= cnt_q + CNTW'(1);
               end
            end
            S_WRITE: begin
               wr_en_q <= 1'b0;
               if (last_pix) begin
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  core_rst_q <= 1'b1;
                  state_q    <= S_CLR;
                  if (col_q == COL_LAST) begin
                     col_q <= '0;
                     row_q <= row_q + RW'(1);
                  end else begin
                     col_q <= col_q + CW'(1);
                  end
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign ctl_io.busy      = busy_q;
   assign ctl_io.done      = done_q;
   assign ctl_io.rd_addr   = rd_addr_q;
   // An abort arriving during the write cycle suppresses that write.
   assign ctl_io.wr_en     = wr_en_q & ~ctl_io.abort;
   assign ctl_io.wr_addr   = wr_addr_q;
   assign ctl_io.wr_data   = wr_data_q;
   assign ctl_io.core_rst  = core_rst_q;
   assign ctl_io.core_en   = core_en_q;
   assign ctl_io.core_data = core_en_q ? ctl_io.rd_data : '0;
endmodule
`default_nettype wire
